seq_detect_ctrl: RTL and testbench

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

---
 rtl/seq_detect_ctrl.sv | 118 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Serial 4-bit pattern detector with start/abort run control and an optional match limit.
// Build option: define SEQ_DETECT_OVERLAP_EN to keep window history across a match (overlapping matches count).
module seq_detect_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] pattern,
    input  logic [7:0] match_limit,
    input  logic       sequence_in,
    input  logic       sequence_valid,
    output logic       busy,
    output logic       done,
    output logic       detector_out,
    output logic [7:0] match_count
);

    // state | meaning
    // IDLE  | waiting for start; serial input ignored
    // RUN   | shifting qualified bits, counting matches
    // DONE  | match limit reached; count held until next start
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] window, window_nxt;
    logic [3:0] pat_q, pat_nxt;
    logic [7:0] limit_q, limit_nxt;
    logic [7:0] count_nxt;
    logic [2:0] seen, seen_nxt;
    logic       det_nxt;

    logic [3:0] shifted;
    logic [2:0] seen_inc;
    logic [7:0] count_inc;
    logic       hit;

    always_comb begin
        shifted   = {window[2:0], sequence_in};
        seen_inc  = (seen == 3'd4) ? 3'd4 : seen + 3'd1;
        count_inc = (match_count == 8'hFF) ? 8'hFF : match_count + 8'd1;
        hit       = sequence_valid && (seen_inc == 3'd4) && (shifted == pat_q);
    end

    always_comb begin
        state_nxt  = state;
        window_nxt = window;
        seen_nxt   = seen;
        pat_nxt    = pat_q;
        limit_nxt  = limit_q;
        count_nxt  = match_count;
        det_nxt    = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        pat_nxt    = pattern;
                        limit_nxt  = match_limit;
                        window_nxt = 4'd0;
                        seen_nxt   = 3'd0;
                        count_nxt  = 8'd0;
                        state_nxt  = RUN;
                    end
                end
                RUN: begin
                    if (sequence_valid) begin
                        window_nxt = shifted;
                        seen_nxt   = seen_inc;
                        if (hit) begin
                            det_nxt   = 1'b1;
                            count_nxt = count_inc;
                            if ((limit_q != 8'd0) && (count_inc == limit_q)) begin
                                state_nxt = DONE;
                            end
`ifdef SEQ_DETECT_OVERLAP_EN
                            seen_nxt = seen_inc;
`else
                            // next match must be built from four fresh bits
                            seen_nxt = 3'd0;
`endif
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            window       <= 4'd0;
            seen         <= 3'd0;
            pat_q        <= 4'd0;
            limit_q      <= 8'd0;
            match_count  <= 8'd0;
            detector_out <= 1'b0;
        end else begin
            state        <= state_nxt;
            window       <= window_nxt;
            seen         <= seen_nxt;
            pat_q        <= pat_nxt;
            limit_q      <= limit_nxt;
            match_count  <= count_nxt;
            detector_out <= det_nxt;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed table, corner sequences, and random run vs. a queue-based model.
module tb_seq_detect_ctrl;

`ifdef SEQ_DETECT_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] pattern = 4'd0;
    logic [7:0] match_limit = 8'd0;
    logic       sequence_in = 1'b0;
    logic       sequence_valid = 1'b0;
    logic       busy;
    logic       done;
    logic       detector_out;
    logic [7:0] match_count;

    int n_cmp = 0;
    int n_err = 0;

    seq_detect_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .pattern        (pattern),
        .match_limit    (match_limit),
        .sequence_in    (sequence_in),
        .sequence_valid (sequence_valid),
        .busy           (busy),
        .done           (done),
        .detector_out   (detector_out),
        .match_count    (match_count)
    );

    always #5 clock = ~clock;

    // Reference model: 0 idle, 1 running, 2 finished; history holds valid bits since the last clear
    int       m_mode = 0;
    bit       m_det = 1'b0;
    int       m_count = 0;
    bit [3:0] m_pat = 4'd0;
    int       m_lim = 0;
    bit       hist[$];

    task automatic model_edge(input bit r, input bit s, input bit a, input bit v, input bit d);
        int sz;
        bit [3:0] w;
        m_det = 1'b0;
        if (r) begin
            m_mode = 0; m_count = 0; m_pat = 4'd0; m_lim = 0; hist.delete();
        end else if (a) begin
            m_mode = 0;
        end else if (m_mode != 1) begin
            if (s) begin
                m_pat = pattern; m_lim = int'(match_limit); m_count = 0; hist.delete(); m_mode = 1;
            end
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 4) void'(hist.pop_front());
            sz = hist.size();
            if (sz == 4) begin
                w = {hist[0], hist[1], hist[2], hist[3]};
                if (w == m_pat) begin
                    m_det = 1'b1;
                    if (m_count < 255) m_count = m_count + 1;
                    if (m_lim != 0 && m_count == m_lim) m_mode = 2;
                    if (!OVL) hist.delete();
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit a, input bit v, input bit d);
        reset = r; start = s; abort = a; sequence_valid = v; sequence_in = d;
        @(posedge clock);
        #1;
        model_edge(r, s, a, v, d);
        chk("model_busy", int'(busy), int'(m_mode == 1));
        chk("model_done", int'(done), int'(m_mode == 2));
        chk("model_det", int'(detector_out), int'(m_det));
        chk("model_count", int'(match_count), m_count);
    endtask

    typedef struct {
        bit r, s, a, v, d;
        bit eb, ed, edet;
        int ecnt;
    } vec_t;

    vec_t tbl[15];

    initial begin
        bit seen_pulse;

        // r s a v d | busy done det count   (pattern 1011, limit 0)
        tbl[0]  = '{1,0,0,0,0, 0,0,0, 0};
        tbl[1]  = '{0,1,0,0,0, 1,0,0, 0};
        tbl[2]  = '{0,0,0,1,1, 1,0,0, 0};
        tbl[3]  = '{0,0,0,1,0, 1,0,0, 0};
        tbl[4]  = '{0,0,0,0,1, 1,0,0, 0};
        tbl[5]  = '{0,0,0,0,0, 1,0,0, 0};
        tbl[6]  = '{0,0,0,1,1, 1,0,0, 0};
        tbl[7]  = '{0,0,0,1,1, 1,0,1, 1};
        tbl[8]  = '{0,0,0,0,0, 1,0,0, 1};
        tbl[9]  = '{0,1,0,1,1, 1,0,0, 1};
        tbl[10] = '{0,1,1,1,1, 0,0,0, 1};
        tbl[11] = '{0,0,0,1,1, 0,0,0, 1};
        tbl[12] = '{0,1,0,0,0, 1,0,0, 0};
        tbl[13] = '{0,0,0,1,1, 1,0,0, 0};
        tbl[14] = '{1,0,0,1,1, 0,0,0, 0};

        pattern = 4'b1011;
        match_limit = 8'd0;
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].ed));
            chk($sformatf("tbl%0d_det", i), int'(detector_out), int'(tbl[i].edet));
            chk($sformatf("tbl%0d_count", i), int'(match_count), tbl[i].ecnt);
        end

        // Reset held three cycles in the middle of a run with a pending match
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_det", int'(detector_out), 0);
        chk("rst_count", int'(match_count), 0);

        // Overlap: 1011 against 1,0,1,1,0,1,1
        pattern = 4'b1011; match_limit = 8'd0;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1, (i == 1 || i == 4) ? 1'b0 : 1'b1);
            chk($sformatf("ovl_det_bit%0d", i + 1), int'(detector_out), int'(i == 3 || (OVL && i == 6)));
        end
        chk("ovl_count", int'(match_count), OVL ? 2 : 1);
        step(0, 0, 1, 0, 0);

        // Limit: 1111 with limit 3 against seven 1s
        pattern = 4'b1111; match_limit = 8'd3;
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 0, 1, 1);
            chk($sformatf("lim_det_bit%0d", i + 1), int'(detector_out),
                int'(OVL ? (i >= 3 && i <= 5) : (i == 3)));
            chk($sformatf("lim_done_bit%0d", i + 1), int'(done), int'(OVL && i >= 5));
        end
        chk("lim_count", int'(match_count), OVL ? 3 : 1);
        step(0, 0, 1, 0, 0);

        // Saturation: pattern 0000, unlimited, long run of zeros
        pattern = 4'b0000; match_limit = 8'd0;
        step(0, 1, 0, 0, 0);
        seen_pulse = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            step(0, 0, 0, 1, 0);
            if (i >= 1090 && detector_out) seen_pulse = 1'b1;
        end
        chk("sat_count", int'(match_count), 255);
        chk("sat_pulses_continue", int'(seen_pulse), 1);
        chk("sat_busy", int'(busy), 1);
        step(0, 0, 1, 0, 0);

        // Randomized control and data against the model
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 8) == 0) pattern = 4'($urandom);
            if (($urandom % 8) == 0) match_limit = 8'($urandom_range(0, 6));
            step(($urandom % 300) == 0, ($urandom % 20) == 0, ($urandom % 60) == 0,
                 ($urandom % 4) != 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
